oled_text_ctrl: RTL and testbench
=================================

Name: oled_text_ctrl

Overview:
- Sequences received UART keyboard bytes into an OLED character RAM (COLS x ROWS cells, one byte per cell, address = row*COLS + col).
- Consumes the uart_rx byte stream through a small input FIFO.
- Interprets printable, backspace, CR, LF and form-feed codes, and maintains the cursor.
- Arbitrates the single-port character RAM between its own writes and the OLED refresh reader; the reader always wins.

Parameters:
- COLS, 16, characters per row.
- ROWS, 4, number of rows.
- FIFO_DEPTH, 4, input byte FIFO entries (power of 2, >=2).
- ADDR_W, 6, character RAM address width (>= clog2(COLS*ROWS)).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from uart_rx
- rx_valid  in  1  one-cycle strobe, rx_data valid
- disp_req  in  1  refresh reader requests RAM this cycle
- disp_addr  in  ADDR_W  refresh read address
- disp_gnt  out  1  refresh reader owns RAM this cycle
- ram_addr  out  ADDR_W  character RAM address
- ram_wdata  out  8  character RAM write data
- ram_we  out  1  character RAM write enable
- cursor_row  out  clog2(ROWS)  current cursor row
- cursor_col  out  clog2(COLS)  current cursor column
- busy  out  1  FIFO non-empty or FSM not IDLE
- drop_cnt  out  8  bytes lost to FIFO full, saturating at 255

Behaviour:
- Reset (async assert, sync release): FIFO empty, FSM IDLE, cursor 0/0, drop_cnt 0, ram_we 0, busy 0.
- Input FIFO:
  - Push on rx_valid when not full.
  - When full, the byte is dropped and drop_cnt increments (saturates at 255).
  - Simultaneous push and pop while full: pop first, then push accepted (no drop).
- Arbitration (combinational):
  - disp_gnt = disp_req.
  - ram_addr = disp_req ? disp_addr : write address.
  - ram_we = write pending & ~disp_req.
  - A stalled write holds its address and data until granted. No starvation guarantee; the refresh reader must leave idle cycles.
- FSM states: IDLE, DECODE, WRITE, CLEAR.
  - IDLE: if FIFO non-empty, pop the byte into a register and go to DECODE. A byte pushed at cycle t is popped at t+1 at the earliest.
  - DECODE, by byte code:
    - 0x20..0x7E: write the char at the cursor; WRITE.
    - 0x08 backspace: if cursor != 0/0, step back one cell (col 0 goes to COLS-1 of the previous row), write 0x20 at the new cursor; WRITE. At 0/0 it is a no-op; IDLE.
    - 0x0D: col = 0; IDLE.
    - 0x0A: col = 0, row = (row+1) mod ROWS; IDLE.
    - 0x0C: CLEAR.
    - Any other code: ignored; IDLE.
  - WRITE: assert the write until a cycle with ram_we=1 (earliest DECODE+1). On that cycle advance the cursor for printable chars only:
    - col+1;
    - col == COLS-1 wraps to col 0, row+1;
    - last cell wraps to 0/0 (no scroll).
    - Then IDLE.
  - CLEAR:
    - Writes 0x20 to addresses 0..COLS*ROWS-1 in ascending order, one per granted cycle; the counter advances only when ram_we=1.
    - After the last address: cursor = 0/0, IDLE.
    - Takes COLS*ROWS cycles minimum (64 at defaults).
    - FIFO keeps accepting bytes during CLEAR.
- busy is combinational from FIFO and FSM state.
- Reset mid-CLEAR or mid-WRITE: abort immediately and return to reset values; partially written RAM contents are not repaired.

Optional Feature:
- Macro: LED_MIRROR_EN.
- Defined: adds output leds[9:0], reset 0. When a digit byte '0'..'9' (0x30..0x39) completes WRITE, leds <= 1 << (byte - 0x30) on the same cycle as the write grant. Non-digit bytes leave leds unchanged; CLEAR leaves leds unchanged.
- Not defined: leds port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, send 'A' (0x41) with disp_req=0 -> ram_we=1 with ram_addr=0, ram_wdata=0x41 two cycles after rx_valid; cursor becomes 0/1; busy returns to 0.
- Send 16 x 'x' then 'y' -> 'y' written at addr 16; cursor 1/1. Fill all 64 cells -> the 65th char is written at addr 0 (wrap).
- From cursor 1/0 send 0x08 -> space (0x20) written at addr 15, cursor 0/15. At 0/0 send 0x08 -> no write, cursor stays 0/0.
- Send 0x0C while holding disp_req high on every 2nd cycle -> exactly 64 writes of 0x20 at addrs 0..63 in order; never ram_we=1 while disp_gnt=1; cursor 0/0 at end.
- Hold disp_req=1 continuously and send 6 bytes back-to-back -> first 4 queued (1 popped into DECODE, FIFO refills), drop_cnt=1. Release disp_req -> queued writes complete in order.
- With LED_MIRROR_EN: send '7' -> leds=0x080. Send 'B' -> leds unchanged. Without the macro, the build has no leds port.

Source files
------------

// File: rtl/oled_text_ctrl.sv
// oled_text_ctrl: turns a UART keyboard byte stream into character RAM writes with cursor handling.
// Optional feature macro LED_MIRROR_EN adds a leds[9:0] one-hot mirror of the last written digit.
module oled_text_ctrl #(
  parameter int COLS       = 16,
  parameter int ROWS       = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 6,
  localparam int RW        = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW        = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  output logic [RW-1:0]     cursor_row,
  output logic [CW-1:0]     cursor_col,
  output logic              busy,
  output logic [7:0]        drop_cnt
`ifdef LED_MIRROR_EN
  ,
  output logic [9:0]        leds
`endif
);

  localparam int PW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CELLS = COLS * ROWS;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_WRITE, S_CLEAR} state_t;

  logic [7:0]        fifo_mem_q [FIFO_DEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [PW:0]       count_q;
  logic [7:0]        drop_cnt_q;
  logic              fifo_empty_s, fifo_full_s, pop_s, push_s, drop_s;

  state_t            state_q;
  logic [7:0]        byte_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              adv_q;
  logic [RW-1:0]     row_q;
  logic [CW-1:0]     col_q;
  logic [9:0]        leds_q;
  logic [ADDR_W-1:0] cur_addr_s;
  logic              ram_we_s;
  logic              at_last_col_s, at_last_row_s;

  assign fifo_empty_s = (count_q == {(PW+1){1'b0}});
  assign fifo_full_s  = (count_q == (PW+1)'(FIFO_DEPTH));
  assign pop_s        = (state_q == S_IDLE) && !fifo_empty_s;
  // A full FIFO still accepts a byte when the same cycle pops one.
  assign push_s       = rx_valid && (!fifo_full_s || pop_s);
  assign drop_s       = rx_valid && fifo_full_s && !pop_s;

  assign cur_addr_s    = ADDR_W'(row_q) * ADDR_W'(COLS) + ADDR_W'(col_q);
  assign at_last_col_s = (col_q == CW'(COLS - 1));
  assign at_last_row_s = (row_q == RW'(ROWS - 1));
  assign ram_we_s      = ((state_q == S_WRITE) || (state_q == S_CLEAR)) && !disp_req;

  assign disp_gnt   = disp_req;
  assign ram_addr   = disp_req ? disp_addr : wr_addr_q;
  assign ram_wdata  = wr_data_q;
  assign ram_we     = ram_we_s;
  assign cursor_row = row_q;
  assign cursor_col = col_q;
  assign busy       = !fifo_empty_s || (state_q != S_IDLE);
  assign drop_cnt   = drop_cnt_q;
`ifdef LED_MIRROR_EN
  assign leds       = leds_q;
`endif

  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= {PW{1'b0}};
      wr_ptr_q   <= {PW{1'b0}};
      count_q    <= {(PW+1){1'b0}};
      drop_cnt_q <= 8'h00;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_s)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
      if (drop_s && (drop_cnt_q != 8'hFF)) drop_cnt_q <= drop_cnt_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      byte_q    <= 8'h00;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= 8'h00;
      adv_q     <= 1'b0;
      row_q     <= {RW{1'b0}};
      col_q     <= {CW{1'b0}};
      leds_q    <= 10'h000;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            byte_q  <= fifo_mem_q[rd_ptr_q];
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          if ((byte_q >= 8'h20) && (byte_q <= 8'h7E)) begin
            wr_addr_q <= cur_addr_s;
            wr_data_q <= byte_q;
            adv_q     <= 1'b1;
            state_q   <= S_WRITE;
          end else begin
            case (byte_q)
              8'h08: begin
                // Previous cell is always the linear address minus one.
                if ((row_q != {RW{1'b0}}) || (col_q != {CW{1'b0}})) begin
                  if (col_q == {CW{1'b0}}) begin
                    col_q <= CW'(COLS - 1);
                    row_q <= row_q - RW'(1);
                  end else begin
                    col_q <= col_q - CW'(1);
                  end
                  wr_addr_q <= cur_addr_s - ADDR_W'(1);
                  wr_data_q <= 8'h20;
                  adv_q     <= 1'b0;
                  state_q   <= S_WRITE;
                end else begin
                  state_q <= S_IDLE;
                end
              end
              8'h0D: begin
                col_q   <= {CW{1'b0}};
                state_q <= S_IDLE;
              end
              8'h0A: begin
                col_q   <= {CW{1'b0}};
                row_q   <= at_last_row_s ? {RW{1'b0}} : row_q + RW'(1);
                state_q <= S_IDLE;
              end
              8'h0C: begin
                wr_addr_q <= {ADDR_W{1'b0}};
                wr_data_q <= 8'h20;
                adv_q     <= 1'b0;
                state_q   <= S_CLEAR;
              end
              default: state_q <= S_IDLE;
            endcase
          end
        end
        S_WRITE: begin
          if (ram_we_s) begin
            if (adv_q) begin
              if (at_last_col_s) begin
                col_q <= {CW{1'b0}};
                row_q <= at_last_row_s ? {RW{1'b0}} : row_q + RW'(1);
              end else begin
                col_q <= col_q + CW'(1);
              end
              if ((byte_q >= 8'h30) && (byte_q <= 8'h39)) begin
                leds_q <= 10'b00_0000_0001 << (byte_q - 8'h30);
              end
            end
            state_q <= S_IDLE;
          end
        end
        S_CLEAR: begin
          if (ram_we_s) begin
            if (wr_addr_q == ADDR_W'(CELLS - 1)) begin
              row_q   <= {RW{1'b0}};
              col_q   <= {CW{1'b0}};
              state_q <= S_IDLE;
            end else begin
              wr_addr_q <= wr_addr_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifndef LED_MIRROR_EN
  logic unused_leds_s;
  assign unused_leds_s = ^leds_q;
`endif

endmodule

// File: tb/tb_oled_text_ctrl.sv
// Directed self-checking bench for oled_text_ctrl: text entry, control codes, clear, arbitration, FIFO drops.
module tb_oled_text_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       disp_req = 1'b0;
  logic [5:0] disp_addr = 6'h2A;
  logic       disp_gnt;
  logic [5:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic [1:0] cursor_row;
  logic [3:0] cursor_col;
  logic       busy;
  logic [7:0] drop_cnt;
`ifdef LED_MIRROR_EN
  logic [9:0] leds;
`endif

  oled_text_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_gnt(disp_gnt),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .cursor_row(cursor_row), .cursor_col(cursor_col), .busy(busy),
    .drop_cnt(drop_cnt)
`ifdef LED_MIRROR_EN
    , .leds(leds)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic       tog_en = 1'b0;
  logic       hold_req = 1'b0;
  int         conflicts = 0;
  logic [7:0] wa_log[$];
  logic [7:0] wd_log[$];

  // Refresh-reader model: either follows hold_req or requests every other cycle.
  always begin
    @(posedge clk);
    #2;
    disp_req = tog_en ? ~disp_req : hold_req;
  end

  // Write logger and arbitration watchdog.
  always @(negedge clk) begin
    if (rst_n && ram_we) begin
      wa_log.push_back({2'b00, ram_addr});
      wd_log.push_back(ram_wdata);
    end
    if (rst_n && (disp_gnt !== disp_req || (disp_gnt && (ram_we || ram_addr !== disp_addr))))
      conflicts++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; rx_valid = 1'b0; tog_en = 1'b0; hold_req = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wa_log.delete(); wd_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic send_wait(input logic [7:0] b);
    send_byte(b);
    wait_idle("idle_timeout", 20);
  endtask

  task automatic chk_cursor(input string tag, input int r, input int c);
    chk(tag, {26'd0, cursor_row, cursor_col}, (r << 4) | c);
  endtask

  initial begin
    int bad;
    apply_reset();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_we", {31'd0, ram_we}, 32'd0);
    chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
    chk_cursor("rst_cursor", 0, 0);

    // Single printable char
    send_byte(8'h41);
    chk("a_busy", {31'd0, busy}, 32'd1);
    wait_idle("a_idle", 20);
    chk("a_nwr", wa_log.size(), 32'd1);
    if (wa_log.size() > 0) begin
      chk("a_addr", {24'd0, wa_log[0]}, 32'd0);
      chk("a_data", {24'd0, wd_log[0]}, 32'h41);
    end
    chk_cursor("a_cursor", 0, 1);

    // Row wrap at end of line
    apply_reset();
    for (int i = 0; i < 16; i++) send_wait(8'h78);
    send_wait(8'h79);
    chk("y_nwr", wa_log.size(), 32'd17);
    if (wa_log.size() == 17) begin
      chk("y_addr", {24'd0, wa_log[16]}, 32'd16);
      chk("y_data", {24'd0, wd_log[16]}, 32'h79);
    end
    chk_cursor("y_cursor", 1, 1);

    // Backspace across row boundary, CR, and backspace at home
    apply_reset();
    for (int i = 0; i < 16; i++) send_wait(8'h78);
    chk_cursor("bs_pre", 1, 0);
    wa_log.delete(); wd_log.delete();
    send_wait(8'h08);
    chk("bs_nwr", wa_log.size(), 32'd1);
    if (wa_log.size() == 1) begin
      chk("bs_addr", {24'd0, wa_log[0]}, 32'd15);
      chk("bs_data", {24'd0, wd_log[0]}, 32'h20);
    end
    chk_cursor("bs_cursor", 0, 15);
    send_wait(8'h0D);
    chk_cursor("cr_cursor", 0, 0);
    send_wait(8'h08);
    chk("bs00_nwr", wa_log.size(), 32'd1);
    chk_cursor("bs00_cursor", 0, 0);

    // Line feed and row wrap, ignored code
    send_wait(8'h41);
    send_wait(8'h0A);
    chk_cursor("lf1_cursor", 1, 0);
    send_wait(8'h0A); send_wait(8'h0A); send_wait(8'h0A);
    chk_cursor("lf4_cursor", 0, 0);
    send_wait(8'h41);
    send_wait(8'h01);
    chk_cursor("ign_cursor", 0, 1);
    chk("ign_nwr", wa_log.size(), 32'd3);

    // Screen wrap: 65th char lands at address 0
    apply_reset();
    for (int i = 0; i < 65; i++) send_wait(8'h61 + 8'(i % 26));
    chk("wrap_nwr", wa_log.size(), 32'd65);
    if (wa_log.size() == 65) begin
      chk("wrap_addr63", {24'd0, wa_log[63]}, 32'd63);
      chk("wrap_addr64", {24'd0, wa_log[64]}, 32'd0);
      chk("wrap_data64", {24'd0, wd_log[64]}, 32'h6D);
    end
    chk_cursor("wrap_cursor", 0, 1);
    chk("wrap_drop", {24'd0, drop_cnt}, 32'd0);

    // Clear with the reader taking every other cycle
    wa_log.delete(); wd_log.delete();
    conflicts = 0;
    send_byte(8'h0C);
    tog_en = 1'b1;
    wait_idle("clr_idle", 400);
    tog_en = 1'b0;
    hold_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_nwr", wa_log.size(), 32'd64);
    bad = 0;
    for (int i = 0; i < wa_log.size(); i++)
      if (wa_log[i] != 8'(i) || wd_log[i] != 8'h20) bad++;
    chk("clr_order", bad, 32'd0);
    chk("clr_conflict", conflicts, 32'd0);
    chk_cursor("clr_cursor", 0, 0);

    // Reader holds RAM while six bytes arrive back-to-back
    wa_log.delete(); wd_log.delete();
    hold_req = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      rx_data = 8'h61 + 8'(i); rx_valid = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_drop", {24'd0, drop_cnt}, 32'd1);
    chk("hold_nwr", wa_log.size(), 32'd0);
    chk("hold_busy", {31'd0, busy}, 32'd1);
    hold_req = 1'b0;
    wait_idle("hold_idle", 60);
    chk("hold_nwr_after", wa_log.size(), 32'd5);
    bad = 0;
    for (int i = 0; i < wa_log.size(); i++)
      if (wa_log[i] != 8'(i) || wd_log[i] != 8'h61 + 8'(i)) bad++;
    chk("hold_order", bad, 32'd0);
    chk_cursor("hold_cursor", 0, 5);
    chk("hold_conflict", conflicts, 32'd0);

`ifdef LED_MIRROR_EN
    send_wait(8'h37);
    chk("led_7", {22'd0, leds}, 32'h080);
    send_wait(8'h42);
    chk("led_b", {22'd0, leds}, 32'h080);
`endif

    // Asynchronous reset in the middle of a clear
    send_byte(8'h0C);
    repeat (10) @(negedge clk);
    chk("mid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd0);
    chk("mid_we", {31'd0, ram_we}, 32'd0);
    chk("mid_drop", {24'd0, drop_cnt}, 32'd0);
    chk_cursor("mid_cursor", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_busy", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
